// File: rtl/alloc_pool.sv
// ---------------------------------------------------------------------------
// alloc_pool
//
// Cell allocator for a block-RAM pool of CELLS cells of DATA_SZ bits. Cell 0
// is reserved as NIL. Cells that have never been used are handed out in
// ascending order from a "top" pointer. Freed cells are pushed onto a LIFO
// free list whose links live inside the free cells themselves, and ALLOC
// takes from that list before it touches the top pointer. A per-cell
// allocation bitmap rejects double-free and any access to an unallocated
// cell.
//
// Ports
//   i_clk       system clock
//   i_rst       synchronous active-high reset (RAM contents are kept)
//   i_req       request strobe, sampled only while o_ready=1
//   i_op        0=READ, 1=WRITE, 2=ALLOC, 3=FREE
//   i_addr      target cell for READ/WRITE/FREE
//   i_data      write data (WRITE) or initial cell value (ALLOC)
//   o_ready     idle; a request can be accepted
//   o_done      one-cycle completion pulse
//   o_error     the operation was rejected (valid with o_done)
//   o_addr      ALLOC result (0 on error), held until the next ALLOC completes
//   o_data      READ result, held until the next successful READ
//   o_used_cnt  number of allocated cells
//   o_free_cnt  CELLS-1-o_used_cnt
// ---------------------------------------------------------------------------
module alloc_pool #(
    parameter int CELLS   = 256,
    parameter int ADDR_SZ = 8,
    parameter int DATA_SZ = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req,
    input  logic [1:0]         i_op,
    input  logic [ADDR_SZ-1:0] i_addr,
    input  logic [DATA_SZ-1:0] i_data,
    output logic               o_ready,
    output logic               o_done,
    output logic               o_error,
    output logic [ADDR_SZ-1:0] o_addr,
    output logic [DATA_SZ-1:0] o_data,
    output logic [ADDR_SZ:0]   o_used_cnt,
    output logic [ADDR_SZ:0]   o_free_cnt
);

    // RAM index width; valid addresses are always < CELLS, so truncating an
    // address to this width loses nothing on the paths that write.
    localparam int IDX_SZ = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [ADDR_SZ:0] CELLS_W = (ADDR_SZ+1)'(CELLS);
    localparam logic [ADDR_SZ:0] CNT_ONE = (ADDR_SZ+1)'(1);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_ALLOC = 2'd2;
    localparam logic [1:0] OP_FREE  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        AL_LINK,
        AL_WRITE,
        DONE
    } state_t;

    state_t               state;
    logic [ADDR_SZ-1:0]   head;      // free-list head, 0 = empty
    logic [ADDR_SZ:0]     top;       // next never-used cell, CELLS = exhausted
    logic [CELLS-1:0]     bitmap;    // 1 = cell allocated
    logic [DATA_SZ-1:0]   data_q;    // ALLOC value held across the link read
    logic [DATA_SZ-1:0]   rd_q;      // synchronous RAM read data
    logic [DATA_SZ-1:0]   mem [CELLS];

    // One-hot decode of a cell number; all-zero for numbers outside the pool,
    // which makes bitmap lookups of out-of-range addresses read as "free".
    function automatic logic [CELLS-1:0] onehot(input logic [ADDR_SZ:0] a);
        logic [CELLS-1:0] r;
        r = '0;
        for (int i = 0; i < CELLS; i++) begin
            r[i] = (a == (ADDR_SZ+1)'(i));
        end
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Request decode at acceptance
    // ---------------------------------------------------------------------
    logic               accept;
    logic [ADDR_SZ:0]   addr_ext;
    logic               addr_ok;
    logic               list_empty;
    logic               pool_full;
    logic               req_err;

    assign accept     = i_req && o_ready;
    assign addr_ext   = {1'b0, i_addr};
    assign addr_ok    = (i_addr != '0) && (addr_ext < CELLS_W) &&
                        (|(bitmap & onehot(addr_ext)));
    assign list_empty = (head == '0);
    assign pool_full  = list_empty && (top == CELLS_W);
    assign req_err    = (i_op == OP_ALLOC) ? pool_full : !addr_ok;

    assign o_free_cnt = (CELLS_W - CNT_ONE) - o_used_cnt;

    // ---------------------------------------------------------------------
    // RAM port steering: one write port, one synchronous read port.
    // ---------------------------------------------------------------------
    logic               wr_en;
    logic [IDX_SZ-1:0]  wr_idx;
    logic [DATA_SZ-1:0] wr_data;
    logic [IDX_SZ-1:0]  rd_idx;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        rd_idx  = i_addr[IDX_SZ-1:0];

        if (state == AL_LINK) begin
            rd_idx = head[IDX_SZ-1:0];
        end

        if (!i_rst) begin
            if (accept && !req_err) begin
                unique case (i_op)
                    OP_WRITE: begin
                        wr_en   = 1'b1;
                        wr_idx  = i_addr[IDX_SZ-1:0];
                        wr_data = i_data;
                    end
                    OP_FREE: begin
                        // The freed cell stores the old head: it becomes the link.
                        wr_en   = 1'b1;
                        wr_idx  = i_addr[IDX_SZ-1:0];
                        wr_data = DATA_SZ'(head);
                    end
                    OP_ALLOC: begin
                        if (list_empty) begin
                            wr_en   = 1'b1;
                            wr_idx  = top[IDX_SZ-1:0];
                            wr_data = i_data;
                        end
                    end
                    default: ;
                endcase
            end else if (state == AL_WRITE) begin
                wr_en   = 1'b1;
                wr_idx  = head[IDX_SZ-1:0];
                wr_data = data_q;
            end
        end
    end

    // NOTE: the RAM has no reset so it maps onto block RAM; nothing depends
    // on its contents before a cell has been written by ALLOC or FREE.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        rd_q <= mem[rd_idx];
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered outputs
    // ---------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            head       <= '0;
            top        <= CNT_ONE;
            bitmap     <= '0;
            data_q     <= '0;
            o_ready    <= 1'b1;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
            o_addr     <= '0;
            o_data     <= '0;
            o_used_cnt <= '0;
        end else begin
            o_done  <= 1'b0;
            o_error <= 1'b0;

            unique case (state)
                // DONE is the o_done cycle; it accepts requests like IDLE so
                // back-to-back operations lose no cycle.
                IDLE, DONE: begin
                    state <= IDLE;
                    if (i_req) begin
                        if (req_err) begin
                            o_done  <= 1'b1;
                            o_error <= 1'b1;
                            state   <= DONE;
                            if (i_op == OP_ALLOC) begin
                                o_addr <= '0;
                            end
                        end else begin
                            unique case (i_op)
                                OP_READ: begin
                                    state   <= RD_WAIT;
                                    o_ready <= 1'b0;
                                end
                                OP_WRITE: begin
                                    o_done <= 1'b1;
                                    state  <= DONE;
                                end
                                OP_FREE: begin
                                    head       <= i_addr;
                                    bitmap     <= bitmap & ~onehot(addr_ext);
                                    o_used_cnt <= o_used_cnt - CNT_ONE;
                                    o_done     <= 1'b1;
                                    state      <= DONE;
                                end
                                OP_ALLOC: begin
                                    if (!list_empty) begin
                                        data_q  <= i_data;
                                        state   <= AL_LINK;
                                        o_ready <= 1'b0;
                                    end else begin
                                        o_addr     <= top[ADDR_SZ-1:0];
                                        top        <= top + CNT_ONE;
                                        bitmap     <= bitmap | onehot(top);
                                        o_used_cnt <= o_used_cnt + CNT_ONE;
                                        o_done     <= 1'b1;
                                        state      <= DONE;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                RD_WAIT: begin
                    o_data  <= rd_q;
                    o_done  <= 1'b1;
                    o_ready <= 1'b1;
                    state   <= DONE;
                end

                // The link read of mem[head] is issued in this state.
                AL_LINK: begin
                    state <= AL_WRITE;
                end

                AL_WRITE: begin
                    head       <= rd_q[ADDR_SZ-1:0];
                    o_addr     <= head;
                    bitmap     <= bitmap | onehot({1'b0, head});
                    o_used_cnt <= o_used_cnt + CNT_ONE;
                    o_done     <= 1'b1;
                    o_ready    <= 1'b1;
                    state      <= DONE;
                end

                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alloc_pool.sv
// ---------------------------------------------------------------------------
// tb_alloc_pool
//
// Directed walk through the allocator's behaviour on a 4-cell pool (cells
// 1..3 usable) followed by a phase where i_req is held high every cycle with
// random operations. Expected results come from a reference model that keeps
// the pool as plain arrays and a LIFO queue of freed cells.
// ---------------------------------------------------------------------------
module tb_alloc_pool;

    localparam int CELLS   = 4;
    localparam int ADDR_SZ = 3;
    localparam int DATA_SZ = 16;

    localparam int OP_READ  = 0;
    localparam int OP_WRITE = 1;
    localparam int OP_ALLOC = 2;
    localparam int OP_FREE  = 3;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_req;
    logic [1:0]         i_op;
    logic [ADDR_SZ-1:0] i_addr;
    logic [DATA_SZ-1:0] i_data;
    logic               o_ready;
    logic               o_done;
    logic               o_error;
    logic [ADDR_SZ-1:0] o_addr;
    logic [DATA_SZ-1:0] o_data;
    logic [ADDR_SZ:0]   o_used_cnt;
    logic [ADDR_SZ:0]   o_free_cnt;

    alloc_pool #(
        .CELLS  (CELLS),
        .ADDR_SZ(ADDR_SZ),
        .DATA_SZ(DATA_SZ)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_req),
        .i_op      (i_op),
        .i_addr    (i_addr),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .o_done    (o_done),
        .o_error   (o_error),
        .o_addr    (o_addr),
        .o_data    (o_data),
        .o_used_cnt(o_used_cnt),
        .o_free_cnt(o_free_cnt)
    );

    always #5 i_clk = ~i_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: allocation flags, cell contents, LIFO of freed cells.
    int m_free_q[$];
    int m_top;
    bit m_alloc[CELLS];
    int m_mem[CELLS];
    int m_used;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_free_q.delete();
        m_top  = 1;
        m_used = 0;
        foreach (m_alloc[i]) m_alloc[i] = 1'b0;
    endtask

    // Applies one accepted request; returns the expected latency in cycles
    // after the acceptance edge, the error flag and the ALLOC/READ result.
    task automatic model_accept(input int op, input int addr, input int data,
                                output int lat, output bit err, output int val);
        err = 1'b0;
        val = 0;
        lat = 1;
        if (op == OP_ALLOC) begin
            if (m_free_q.size() > 0) begin
                val = m_free_q.pop_front();
                lat = 3;
            end else if (m_top < CELLS) begin
                val = m_top;
                m_top++;
            end else begin
                err = 1'b1;
            end
            if (!err) begin
                m_alloc[val] = 1'b1;
                m_mem[val]   = data;
                m_used++;
            end
        end else if (addr == 0 || addr >= CELLS) begin
            err = 1'b1;
        end else if (!m_alloc[addr]) begin
            err = 1'b1;
        end else begin
            case (op)
                OP_READ: begin
                    val = m_mem[addr];
                    lat = 2;
                end
                OP_WRITE: m_mem[addr] = data;
                default: begin
                    m_alloc[addr] = 1'b0;
                    m_free_q.push_front(addr);
                    m_used--;
                end
            endcase
        end
    endtask

    // One handshake: present the request, scramble the inputs after the
    // acceptance edge, then wait (bounded) for o_done and check everything.
    task automatic run_op(input string tag, input int op, input int addr, input int data);
        int lat;
        bit err;
        int val;
        int cyc;
        @(negedge i_clk);
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
        i_req  = 1'b1;
        i_op   = 2'(op);
        i_addr = ADDR_SZ'(addr);
        i_data = DATA_SZ'(data);
        model_accept(op, addr, data, lat, err, val);
        @(posedge i_clk);
        #1;
        i_req  = 1'b0;
        i_op   = 2'($urandom);
        i_addr = ADDR_SZ'($urandom);
        i_data = DATA_SZ'($urandom);
        cyc = 1;
        while (!o_done && cyc < 8) begin
            @(posedge i_clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_error"}, 32'(o_error), 32'(err));
        if (op == OP_ALLOC) check({tag, "_addr"}, 32'(o_addr), 32'(val));
        if (op == OP_READ && !err) check({tag, "_data"}, 32'(o_data), 32'(val));
        check({tag, "_used"}, 32'(o_used_cnt), 32'(m_used));
        check({tag, "_free"}, 32'(o_free_cnt), 32'(CELLS - 1 - m_used));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_quiet;
        int pend;
        int exp_cyc;
        int exp_op;
        int exp_val;
        bit exp_err;
        int cyc;
        int n_acc;
        int n_done;

        // ---------------- reset ----------------
        i_rst  = 1'b1;
        i_req  = 1'b0;
        i_op   = '0;
        i_addr = '0;
        i_data = '0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_error", 32'(o_error), 32'd0);
        check("rst_addr", 32'(o_addr), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_used", 32'(o_used_cnt), 32'd0);
        check("rst_free", 32'(o_free_cnt), 32'(CELLS - 1));
        i_rst = 1'b0;

        // ---------------- fill the pool from top ----------------
        run_op("alloc1", OP_ALLOC, 0, 'h1111);
        check("alloc1_const", 32'(o_addr), 32'd1);
        run_op("alloc2", OP_ALLOC, 0, 'h2222);
        check("alloc2_const", 32'(o_addr), 32'd2);
        run_op("alloc3", OP_ALLOC, 0, 'h3333);
        check("alloc3_const", 32'(o_addr), 32'd3);
        run_op("alloc_full", OP_ALLOC, 0, 'h4444);
        check("alloc_full_err", 32'(o_error), 32'd1);
        check("alloc_full_addr", 32'(o_addr), 32'd0);
        check("full_free_cnt", 32'(o_free_cnt), 32'd0);

        // ---------------- read / write ----------------
        run_op("read2", OP_READ, 2, 0);
        check("read2_const", 32'(o_data), 32'h2222);
        run_op("write2", OP_WRITE, 2, 'hABCD);
        run_op("read2b", OP_READ, 2, 0);
        check("read2b_const", 32'(o_data), 32'hABCD);

        // ---------------- free and LIFO reuse ----------------
        run_op("free2", OP_FREE, 2, 0);
        run_op("free3", OP_FREE, 3, 0);
        check("free_used_const", 32'(o_used_cnt), 32'd1);
        run_op("realloc_a", OP_ALLOC, 0, 'h5555);
        check("realloc_a_const", 32'(o_addr), 32'd3);
        run_op("realloc_b", OP_ALLOC, 0, 'h6666);
        check("realloc_b_const", 32'(o_addr), 32'd2);
        run_op("read3", OP_READ, 3, 0);
        check("read3_const", 32'(o_data), 32'h5555);

        // ---------------- error cases ----------------
        run_op("free2_once", OP_FREE, 2, 0);
        run_op("free2_twice", OP_FREE, 2, 0);
        check("double_free_err", 32'(o_error), 32'd1);
        check("double_free_used", 32'(o_used_cnt), 32'd2);
        run_op("read_nil", OP_READ, 0, 0);
        run_op("read_oob", OP_READ, CELLS, 0);
        run_op("read_freed", OP_READ, 2, 0);
        check("read_freed_err", 32'(o_error), 32'd1);
        run_op("write_freed", OP_WRITE, 2, 'h9999);

        // ---------------- reset while the free-list link read is in flight ----
        @(negedge i_clk);
        i_req  = 1'b1;
        i_op   = 2'(OP_ALLOC);
        i_data = 16'h7777;
        @(posedge i_clk);
        #1;
        i_req = 1'b0;
        i_rst = 1'b1;
        check("abort_busy", 32'(o_ready), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("abort_no_done", 32'(o_done), 32'd0);
        check("abort_ready", 32'(o_ready), 32'd1);
        check("abort_used", 32'(o_used_cnt), 32'd0);
        check("abort_free", 32'(o_free_cnt), 32'(CELLS - 1));
        n_quiet = 0;
        repeat (4) begin
            @(posedge i_clk);
            #1;
            if (o_done) n_quiet++;
        end
        check("abort_quiet", 32'(n_quiet), 32'd0);
        model_reset();
        run_op("post_rst_alloc", OP_ALLOC, 0, 'h8888);
        check("post_rst_alloc_const", 32'(o_addr), 32'd1);

        // ---------------- i_req every cycle, random ops ----------------
        pend    = 0;
        exp_cyc = 0;
        exp_op  = 0;
        exp_val = 0;
        exp_err = 1'b0;
        cyc     = 0;
        n_acc   = 0;
        n_done  = 0;
        for (int s = 0; s < 400; s++) begin
            int op;
            int addr;
            int data;
            int lat;
            int al[$];
            @(negedge i_clk);
            check("rnd_ready", 32'(o_ready), 32'(pend == 0));
            op   = int'($urandom_range(0, 3));
            data = int'($urandom_range(0, 16'hFFFF));
            al.delete();
            for (int c = 1; c < CELLS; c++) if (m_alloc[c]) al.push_back(c);
            if (al.size() > 0 && $urandom_range(0, 3) != 0)
                addr = al[$urandom_range(0, al.size() - 1)];
            else
                addr = int'($urandom_range(0, 7));
            i_req  = (s < 390);
            i_op   = 2'(op);
            i_addr = ADDR_SZ'(addr);
            i_data = DATA_SZ'(data);
            if (pend == 0 && s < 390) begin
                model_accept(op, addr, data, lat, exp_err, exp_val);
                exp_op  = op;
                exp_cyc = cyc + 1 + lat - 1 + 0;
                exp_cyc = cyc + lat;
                pend    = 1;
                n_acc++;
            end
            @(posedge i_clk);
            cyc++;
            #1;
            if (o_done) begin
                n_done++;
                if (pend != 0) begin
                    check("rnd_done_cycle", 32'(cyc), 32'(exp_cyc));
                    check("rnd_error", 32'(o_error), 32'(exp_err));
                    if (exp_op == OP_ALLOC)
                        check("rnd_alloc_addr", 32'(o_addr), 32'(exp_val));
                    if (exp_op == OP_READ && !exp_err)
                        check("rnd_read_data", 32'(o_data), 32'(exp_val));
                    check("rnd_used", 32'(o_used_cnt), 32'(m_used));
                    check("rnd_sum", 32'(o_used_cnt) + 32'(o_free_cnt), 32'(CELLS - 1));
                    pend = 0;
                end else begin
                    check("rnd_spurious_done", 32'(o_done), 32'd0);
                end
            end else begin
                check("rnd_error_idle", 32'(o_error), 32'd0);
                if (pend != 0 && cyc >= exp_cyc) begin
                    check("rnd_done_missing", 32'(o_done), 32'd1);
                    pend = 0;
                end
            end
        end
        i_req = 1'b0;
        check("rnd_one_done_per_accept", 32'(n_done), 32'(n_acc));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
